// File: rtl/afe_spi_arbiter.sv
// Purpose: arbitrates config and stream requesters onto one AFE SPI master and inserts read-enable mode writes.
// Latency: begin one cycle after IDLE samples a request; done one cycle after in_spi_done (plus one SPI round when a mode write is inserted).
// Backpressure: requests are held until done; the loser waits in IDLE arbitration; a missing in_spi_done ends in a sticky ERR state.
module afe_spi_arbiter #(
    parameter int TIMEOUT_CYC = 4095,
    parameter int STARVE_MAX  = 4
) (
    input  logic        clk,
    input  logic        in_reset_n,
    input  logic        in_cfg_req,
    input  logic        in_cfg_rw,
    input  logic [7:0]  in_cfg_addr,
    input  logic [23:0] in_cfg_wdata,
    output logic        out_cfg_gnt,
    output logic        out_cfg_done,
    output logic [23:0] out_cfg_rdata,
    input  logic        in_str_req,
    input  logic [7:0]  in_str_addr,
    output logic        out_str_gnt,
    output logic        out_str_done,
    output logic [23:0] out_str_rdata,
    output logic        out_spi_begin,
    output logic        out_spi_rw,
    output logic [7:0]  out_spi_addr,
    output logic [23:0] out_spi_wdata,
    input  logic        in_spi_done,
    input  logic [23:0] in_spi_rdata,
    output logic        out_busy,
    output logic        out_timeout_er
);

    typedef enum logic [2:0] {
        IDLE,
        MODE_BEGIN,
        MODE_WAIT,
        XFER_BEGIN,
        XFER_WAIT,
        DONE,
        ERR
    } state_t;

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    // The wait counter is 0 in the first wait cycle, so the ERR transition is
    // taken two counts early: ERR is then entered TIMEOUT_CYC cycles after begin.
    localparam logic [11:0] TMO_LAST = 12'(TIMEOUT_CYC - 2);

    state_t        state;
    state_t        state_nxt;
    logic [SW-1:0] starve_cnt;
    logic [11:0]   tmo_cnt;
    logic          mode;
    logic          owner_cfg;
    logic          lat_rw;
    logic [7:0]    lat_addr;
    logic [23:0]   lat_wdata;
    logic [23:0]   cfg_rdata_q;
    logic [23:0]   str_rdata_q;

    logic          pick_any;
    logic          pick_cfg;
    logic          win_rw;
    logic [7:0]    win_addr;
    logic          win_mode_wr;
    logic          win_need_mode;
    logic          mode_phase;
    logic          in_txn;

    // Arbitration: stream wins ties unless config has been starved STARVE_MAX times
    always_comb begin
        pick_any      = in_cfg_req | in_str_req;
        pick_cfg      = in_cfg_req & (~in_str_req | (starve_cnt == STARVE_LIM));
        win_rw        = pick_cfg ? in_cfg_rw : 1'b0;
        win_addr      = pick_cfg ? in_cfg_addr : in_str_addr;
        // A config write to the mode register sets the mode itself, so it never gets a preamble
        win_mode_wr   = pick_cfg & in_cfg_rw & (in_cfg_addr == 8'h00);
        win_need_mode = win_rw ? (mode & ~win_mode_wr) : ~mode;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (pick_any) state_nxt = win_need_mode ? MODE_BEGIN : XFER_BEGIN;
            MODE_BEGIN: state_nxt = MODE_WAIT;
            MODE_WAIT: begin
                if (in_spi_done)              state_nxt = XFER_BEGIN;
                else if (tmo_cnt == TMO_LAST) state_nxt = ERR;
            end
            XFER_BEGIN: state_nxt = XFER_WAIT;
            XFER_WAIT: begin
                if (in_spi_done)              state_nxt = DONE;
                else if (tmo_cnt == TMO_LAST) state_nxt = ERR;
            end
            DONE:       state_nxt = IDLE;
            ERR:        state_nxt = ERR;
            default:    state_nxt = IDLE;
        endcase
    end

    // Output decode from state and latched transaction fields
    always_comb begin
        mode_phase     = (state == MODE_BEGIN) | (state == MODE_WAIT);
        in_txn         = state inside {MODE_BEGIN, MODE_WAIT, XFER_BEGIN, XFER_WAIT, DONE};
        out_cfg_gnt    = in_txn & owner_cfg;
        out_str_gnt    = in_txn & ~owner_cfg;
        out_cfg_done   = (state == DONE) & owner_cfg;
        out_str_done   = (state == DONE) & ~owner_cfg;
        out_spi_begin  = (state == MODE_BEGIN) | (state == XFER_BEGIN);
        out_spi_rw     = mode_phase ? 1'b1 : lat_rw;
        out_spi_addr   = mode_phase ? 8'h00 : lat_addr;
        // Mode write enables reads (1) before a read, disables them (0) before a write
        out_spi_wdata  = mode_phase ? {23'd0, ~lat_rw} : lat_wdata;
        out_busy       = (state != IDLE);
        out_timeout_er = (state == ERR);
        out_cfg_rdata  = cfg_rdata_q;
        out_str_rdata  = str_rdata_q;
    end

    // State register
    always_ff @(posedge clk or negedge in_reset_n) begin
        if (!in_reset_n) state <= IDLE;
        else             state <= state_nxt;
    end

    // Latch the winner's transaction at grant
    always_ff @(posedge clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            owner_cfg <= 1'b0;
            lat_rw    <= 1'b0;
            lat_addr  <= 8'h00;
            lat_wdata <= 24'h0;
        end else if (state == IDLE && pick_any) begin
            owner_cfg <= pick_cfg;
            lat_rw    <= win_rw;
            lat_addr  <= win_addr;
            lat_wdata <= pick_cfg ? in_cfg_wdata : 24'h0;
        end
    end

    // Starvation counter: counts stream grants taken past a waiting config request
    always_ff @(posedge clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            starve_cnt <= '0;
        end else if (!in_cfg_req) begin
            starve_cnt <= '0;
        end else if (state == IDLE && pick_any) begin
            if (pick_cfg)                      starve_cnt <= '0;
            else if (starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + SW'(1);
        end
    end

    // SPI completion timer, restarted as each wait state is entered
    always_ff @(posedge clk or negedge in_reset_n) begin
        if (!in_reset_n)                                     tmo_cnt <= 12'd0;
        else if (state == MODE_BEGIN || state == XFER_BEGIN) tmo_cnt <= 12'd0;
        else if (state == MODE_WAIT || state == XFER_WAIT)   tmo_cnt <= tmo_cnt + 12'd1;
    end

    // Track the AFE read-enable mode bit
    always_ff @(posedge clk or negedge in_reset_n) begin
        if (!in_reset_n)
            mode <= 1'b0;
        else if (state == MODE_WAIT && in_spi_done)
            mode <= ~lat_rw;
        else if (state == XFER_WAIT && in_spi_done && owner_cfg && lat_rw && lat_addr == 8'h00)
            mode <= lat_wdata[0];
    end

    // Capture read data for the owning requester
    always_ff @(posedge clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            cfg_rdata_q <= 24'h0;
            str_rdata_q <= 24'h0;
        end else if (state == XFER_WAIT && in_spi_done && !lat_rw) begin
            if (owner_cfg) cfg_rdata_q <= in_spi_rdata;
            else           str_rdata_q <= in_spi_rdata;
        end
    end

endmodule
